uart_rx_ctrl: RTL and testbench

UART receive controller driven by the ×16 oversampling tick of the baud-rate generator. It detects start bits, samples each bit at mid-bit using the tick stream, and assembles 8N1 frames, with optional parity. Completed bytes and error flags are presented to the host side as a one-cycle strobe. It sits between the `rx` pad and the UART register/FIFO logic. It owns no divider and consumes the generator's x16 output as `tick16`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t  - receive FSM state encoding
//   OVERSAMPLE  - ticks per bit from the baud generator
//   MID_TICK    - tick_cnt value at which the start bit is re-checked
//   LAST_TICK   - tick_cnt value at which a data/parity bit is sampled
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(15);

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Both flops reset to 1 so an idle-high serial line does not look like a
// start bit coming out of reset.
//   clk     in   system clock
//   reset_n in   asynchronous active-low reset
//   d       in   asynchronous input
//   q       out  synchronized output (2 cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver driven by the x16 oversampling tick.
// Detects the start bit, samples each bit at mid-bit and presents the
// assembled word with error flags as a one-cycle strobe.
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   tick16        in   one-cycle pulse at 16x the baud rate
//   rx            in   serial line, asynchronous, idle high
//   rx_data       out  last received word, held until the next frame
//   rx_valid      out  one-cycle strobe: frame completed
//   rx_frame_err  out  with rx_valid: stop bit sampled low
//   rx_parity_err out  with rx_valid: parity mismatch
//   rx_busy       out  high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for the line to go low on a tick
// START  | counting to the middle of the start bit, rejecting glitches
// DATA   | sampling DBITS data bits, LSB first
// PARITY | sampling the parity bit and latching the mismatch
// STOP   | counting SB_TICKS ticks, sampling the stop level on the last
module uart_rx_ctrl #(
  parameter int DBITS      = 8,
  parameter int SB_TICKS   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick16,
  input  logic             rx,
  output logic [DBITS-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_busy
);

  import uart_pkg::*;

  localparam int BW   = $clog2(DBITS);
  localparam int SB_W = $clog2(SB_TICKS);

  localparam logic [BW-1:0]   BIT_LAST = BW'(DBITS - 1);
  localparam logic [SB_W-1:0] SB_LAST  = SB_W'(SB_TICKS - 1);
  localparam logic            PAR_EN   = (PARITY_EN != 0);
  localparam logic            PAR_ODD  = (PARITY_ODD != 0);

  logic rx_s;

  rx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SB_W-1:0]   sb_cnt_q, sb_cnt_d;
  logic [DBITS-1:0]  sr_q, sr_d;
  logic              par_err_q, par_err_d;
  logic [DBITS-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;

  sync_2ff u_sync_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sb_cnt_d     = sb_cnt_q;
    sr_d         = sr_q;
    par_err_d    = par_err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    if (tick16) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            tick_cnt_d = '0;
            state_d    = START;
          end
        end

        START: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == MID_TICK) begin
            if (!rx_s) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              par_err_d  = 1'b0;
              state_d    = DATA;
            end else begin
              // line came back high before mid-start: glitch, no frame
              state_d = IDLE;
            end
          end
        end

        DATA: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            sr_d       = {rx_s, sr_q[DBITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              sb_cnt_d = '0;
              state_d  = PAR_EN ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        PARITY: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            par_err_d  = rx_s ^ (^sr_q) ^ PAR_ODD;
            sb_cnt_d   = '0;
            state_d    = STOP;
          end
        end

        STOP: begin
          sb_cnt_d = sb_cnt_q + 1'b1;
          if (sb_cnt_q == SB_LAST) begin
            sb_cnt_d     = '0;
            state_d      = IDLE;
            rx_data_d    = sr_q;
            rx_valid_d   = 1'b1;
            frame_err_d  = ~rx_s;
            parity_err_d = PAR_EN & par_err_q;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      sb_cnt_q     <= '0;
      sr_q         <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sb_cnt_q     <= sb_cnt_d;
      sr_q         <= sr_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_parity_err = parity_err_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance
// share clock, reset and tick16; each has its own serial line.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick16;
  logic       rx;
  logic       rx_p;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, rx_valid_p;
  logic       rx_frame_err, rx_frame_err_p;
  logic       rx_parity_err, rx_parity_err_p;
  logic       rx_busy, rx_busy_p;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick16        (tick16),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  uart_rx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick16        (tick16),
    .rx            (rx_p),
    .rx_data       (rx_data_p),
    .rx_valid      (rx_valid_p),
    .rx_frame_err  (rx_frame_err_p),
    .rx_parity_err (rx_parity_err_p),
    .rx_busy       (rx_busy_p)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int div = 1;
  int phase = 0;
  bit hold = 1'b0;
  int line_sel = 0;

  int         n_valid = 0;
  logic [7:0] hist_data [0:31];
  logic       hist_ferr [0:31];
  logic       hist_perr [0:31];
  int         hist_cyc  [0:31];
  int         stray = 0;

  int         p_valid = 0;
  logic [7:0] p_data;
  logic       p_ferr;
  logic       p_perr;

  // One clock: t reports whether a tick was presented to the edge just taken.
  task automatic step(output bit t);
    t = tick16;
    @(negedge clk);
    cyc++;
    if (rx_valid) begin
      if (n_valid < 32) begin
        hist_data[n_valid] = rx_data;
        hist_ferr[n_valid] = rx_frame_err;
        hist_perr[n_valid] = rx_parity_err;
        hist_cyc[n_valid]  = cyc;
      end
      n_valid++;
    end
    if (!rx_valid && (rx_frame_err || rx_parity_err)) stray++;
    if (!rx_valid_p && (rx_frame_err_p || rx_parity_err_p)) stray++;
    if (rx_valid_p) begin
      p_valid++;
      p_data = rx_data_p;
      p_ferr = rx_frame_err_p;
      p_perr = rx_parity_err_p;
    end
    if (hold) tick16 = 1'b0;
    else begin
      tick16 = (phase == 0);
      phase  = (phase + 1) % div;
    end
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) step(t);
  endtask

  task automatic set_line(input logic l);
    if (line_sel == 0) rx = l;
    else rx_p = l;
  endtask

  task automatic send_level(input logic l, input int ticks);
    bit t;
    int n = 0;
    set_line(l);
    while (n < ticks) begin
      step(t);
      if (t) n++;
    end
  endtask

  task automatic freeze(input int n);
    bit t;
    bit busy_ok = 1'b1;
    int v0 = n_valid;
    hold   = 1'b1;
    tick16 = 1'b0;
    repeat (n) begin
      step(t);
      if (rx_busy !== 1'b1) busy_ok = 1'b0;
    end
    hold = 1'b0;
    checks++;
    if (!busy_ok || n_valid != v0) begin
      errors++;
      $display("FAIL freeze: busy_held=%0b strobes=%0d, want busy_held=1 strobes=0",
               busy_ok, n_valid - v0);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                            input bit par, input logic par_lvl, input int freeze_after);
    send_level(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      send_level(d[i], 16);
      if (i == freeze_after) freeze(40);
    end
    if (par) send_level(par_lvl, 16);
    send_level(stop_lvl, 16);
    set_line(1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    rx_p    = 1'b1;
    tick16  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: data=%h v=%b fe=%b pe=%b busy=%b, want all 0",
               rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy);
    end
    checks++;
    if ({rx_data_p, rx_valid_p, rx_busy_p} !== 10'h000) begin
      errors++;
      $display("FAIL reset_outputs_p: data=%h v=%b busy=%b, want all 0",
               rx_data_p, rx_valid_p, rx_busy_p);
    end
    reset_n = 1'b1;
    idle(10);
    checks++;
    if (rx_busy !== 1'b0 || n_valid != 0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b strobes=%0d, want 0 0", rx_busy, n_valid);
    end
  endtask

  task automatic test_latency_55();
    int t0 = cyc;
    int v0 = n_valid;
    line_sel = 0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    checks++;
    if (n_valid != v0 + 1) begin
      errors++;
      $display("FAIL lat55_count: got %0d strobes, want 1", n_valid - v0);
    end else begin
      checks++;
      if (hist_cyc[v0] != t0 + 155) begin
        errors++;
        $display("FAIL lat55_latency: got +%0d, want +155", hist_cyc[v0] - t0);
      end
      checks++;
      if (hist_data[v0] !== 8'h55 || hist_ferr[v0] !== 1'b0 || hist_perr[v0] !== 1'b0) begin
        errors++;
        $display("FAIL lat55_data: data=%h fe=%b pe=%b, want 55 0 0",
                 hist_data[v0], hist_ferr[v0], hist_perr[v0]);
      end
    end
    checks++;
    if (rx_data !== 8'h55) begin
      errors++;
      $display("FAIL lat55_hold: rx_data=%h, want 55", rx_data);
    end
  endtask

  task automatic test_glitch();
    bit t;
    logic b [0:15];
    int v0 = n_valid;
    rx = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step(t);
      b[k] = rx_busy;
      if (k == 3) rx = 1'b1;
    end
    idle(200);
    checks++;
    if (b[2] !== 1'b0 || b[3] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy@+2=%b busy@+3=%b, want 0 1", b[2], b[3]);
    end
    checks++;
    if (b[10] !== 1'b1 || b[11] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_abort: busy@+10=%b busy@+11=%b, want 1 0", b[10], b[11]);
    end
    checks++;
    if (n_valid != v0) begin
      errors++;
      $display("FAIL glitch_no_strobe: got %0d strobes, want 0", n_valid - v0);
    end
  endtask

  task automatic test_frame_err();
    int v0 = n_valid;
    line_sel = 0;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0, -1);
    idle(300);
    checks++;
    if (n_valid != v0 + 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d strobes, want 1", n_valid - v0);
    end else begin
      checks++;
      if (hist_data[v0] !== 8'hA3 || hist_ferr[v0] !== 1'b1 || hist_perr[v0] !== 1'b0) begin
        errors++;
        $display("FAIL ferr_flags: data=%h fe=%b pe=%b, want a3 1 0",
                 hist_data[v0], hist_ferr[v0], hist_perr[v0]);
      end
    end
  endtask

  task automatic test_parity();
    int v0 = p_valid;
    line_sel = 1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1);
    idle(20);
    checks++;
    if (p_valid != v0 + 1 || p_data !== 8'h07 || p_perr !== 1'b0 || p_ferr !== 1'b0) begin
      errors++;
      $display("FAIL parity_ok: strobes=%0d data=%h pe=%b fe=%b, want 1 07 0 0",
               p_valid - v0, p_data, p_perr, p_ferr);
    end
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
    idle(20);
    checks++;
    if (p_valid != v0 + 2 || p_data !== 8'h07 || p_perr !== 1'b1 || p_ferr !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: strobes=%0d data=%h pe=%b fe=%b, want 2 07 1 0",
               p_valid - v0, p_data, p_perr, p_ferr);
    end
    line_sel = 0;
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    line_sel = 0;
    div = 4;
    phase = 0;
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 3);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, -1);
    idle(100);
    div = 1;
    phase = 0;
    checks++;
    if (n_valid != v0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes, want 2", n_valid - v0);
    end else begin
      checks++;
      if (hist_data[v0] !== 8'h12 || hist_data[v0+1] !== 8'h34) begin
        errors++;
        $display("FAIL b2b_data: got %h %h, want 12 34", hist_data[v0], hist_data[v0+1]);
      end
      checks++;
      if (hist_ferr[v0] !== 1'b0 || hist_ferr[v0+1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ferr: got %b %b, want 0 0", hist_ferr[v0], hist_ferr[v0+1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0 = n_valid;
    logic [7:0] d = 8'h5A;
    line_sel = 0;
    send_level(1'b0, 16);
    for (int i = 0; i < 4; i++) send_level(d[i], 16);
    send_level(d[4], 8);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: data=%h v=%b fe=%b pe=%b busy=%b, want all 0",
               rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy);
    end
    rx = 1'b1;
    idle(5);
    reset_n = 1'b1;
    idle(200);
    checks++;
    if (n_valid != v0) begin
      errors++;
      $display("FAIL reset_mid_no_strobe: got %0d strobes, want 0", n_valid - v0);
    end
    send_frame(8'hC9, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    checks++;
    if (n_valid != v0 + 1 || hist_data[v0] !== 8'hC9 || hist_ferr[v0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: strobes=%0d data=%h fe=%b, want 1 c9 0",
               n_valid - v0, hist_data[v0], hist_ferr[v0]);
    end
  endtask

  task automatic test_break();
    int v0 = n_valid;
    line_sel = 0;
    rx = 1'b0;
    idle(350);
    checks++;
    if (n_valid != v0 + 2) begin
      errors++;
      $display("FAIL break_count: got %0d strobes, want 2", n_valid - v0);
    end else begin
      checks++;
      if (hist_data[v0] !== 8'h00 || hist_ferr[v0] !== 1'b1 ||
          hist_data[v0+1] !== 8'h00 || hist_ferr[v0+1] !== 1'b1) begin
        errors++;
        $display("FAIL break_flags: %h/%b %h/%b, want 00/1 00/1",
                 hist_data[v0], hist_ferr[v0], hist_data[v0+1], hist_ferr[v0+1]);
      end
    end
    rx = 1'b1;
    idle(400);
  endtask

  task automatic test_stray_flags();
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL stray_flags: %0d cycles with an error flag outside rx_valid, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_latency_55();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_stray_flags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
